// File: rtl/pll_phase_ctrl.sv
// PLL reset/lock sequencer with a valid/ready port for stepping or loading
// the dynamic phase (psda/dutyda) and fine delay (fdly) of the DDR PLL.
module pll_phase_ctrl #(
  parameter int RESET_CYCLES  = 16,
  parameter int LOCK_STABLE   = 1024,
  parameter int LOCK_TIMEOUT  = 65535,
  parameter int SETTLE_CYCLES = 32,
  parameter int DUTY_OFFSET   = 8,
  parameter int FDLY_INIT     = 0
) (
  input  logic       clkin,
  input  logic       resetn,
  input  logic       lock,
  input  logic       relock_req,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [3:0] cmd_val,
  output logic       pll_reset,
  output logic [3:0] psda,
  output logic [3:0] dutyda,
  output logic [3:0] fdly,
  output logic       ready,
  output logic [7:0] relock_cnt
);

  localparam logic [2:0] ST_RST    = 3'd0;
  localparam logic [2:0] ST_WAIT   = 3'd1;
  localparam logic [2:0] ST_STABLE = 3'd2;
  localparam logic [2:0] ST_READY  = 3'd3;
  localparam logic [2:0] ST_SETTLE = 3'd4;

  // The WAIT_LOCK cycle that first sees lock_s=1 counts toward LOCK_STABLE.
  localparam int STB_LAST = (LOCK_STABLE >= 2) ? LOCK_STABLE - 2 : 0;

  localparam logic [15:0] RST_END = 16'(RESET_CYCLES - 1);
  localparam logic [15:0] TO_END  = 16'(LOCK_TIMEOUT - 1);
  localparam logic [15:0] STB_END = 16'(STB_LAST);
  localparam logic [15:0] SET_END = 16'(SETTLE_CYCLES - 1);
  localparam logic [3:0]  DUTY4   = 4'(DUTY_OFFSET);

  logic [1:0]  lock_ff;
  logic        lock_s;
  logic [2:0]  state, state_nxt;
  logic [15:0] timer, timer_nxt;
  logic [3:0]  psda_nxt, fdly_nxt;
  logic        cnt_inc;

  assign lock_s    = lock_ff[1];
  assign pll_reset = (state == ST_RST);
  assign ready     = (state == ST_READY);
  assign cmd_ready = (state == ST_READY) & lock_s & ~relock_req;

  always_comb begin
    state_nxt = state;
    timer_nxt = timer + 16'd1;
    psda_nxt  = psda;
    fdly_nxt  = fdly;
    cnt_inc   = 1'b0;
    case (state)
      ST_RST:
        if (timer == RST_END) state_nxt = ST_WAIT;
      ST_WAIT:
        if (relock_req) state_nxt = ST_RST;
        else if (lock_s) state_nxt = (LOCK_STABLE == 1) ? ST_READY : ST_STABLE;
        else if (timer == TO_END) begin
          state_nxt = ST_RST;
          cnt_inc   = 1'b1;
        end
      ST_STABLE:
        if (relock_req) state_nxt = ST_RST;
        else if (!lock_s) state_nxt = ST_WAIT;
        else if (timer == STB_END) state_nxt = ST_READY;
      ST_READY:
        if (!lock_s) begin
          state_nxt = ST_RST;
          cnt_inc   = 1'b1;
        end else if (relock_req) state_nxt = ST_RST;
        else if (cmd_valid) begin
          state_nxt = ST_SETTLE;
          case (cmd_op)
            2'd0:    psda_nxt = psda + 4'd1;
            2'd1:    psda_nxt = psda - 4'd1;
            2'd2:    psda_nxt = cmd_val;
            default: fdly_nxt = cmd_val;
          endcase
        end
      ST_SETTLE:
        if (!lock_s) begin
          state_nxt = ST_RST;
          cnt_inc   = 1'b1;
        end else if (relock_req) state_nxt = ST_RST;
        else if (timer == SET_END) state_nxt = ST_READY;
      default:
        state_nxt = ST_RST;
    endcase
    if (state_nxt != state) timer_nxt = 16'd0;
  end

  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      lock_ff    <= 2'b00;
      state      <= ST_RST;
      timer      <= 16'd0;
      psda       <= 4'd0;
      dutyda     <= DUTY4;
      fdly       <= 4'(FDLY_INIT);
      relock_cnt <= 8'd0;
    end else begin
      lock_ff    <= {lock_ff[0], lock};
      state      <= state_nxt;
      timer      <= timer_nxt;
      psda       <= psda_nxt;
      dutyda     <= psda_nxt + DUTY4;
      fdly       <= fdly_nxt;
      if (cnt_inc && relock_cnt != 8'hff) relock_cnt <= relock_cnt + 8'd1;
    end
  end

endmodule
